chip_regs_bank: RTL and testbench
=================================

Name: chip_regs_bank

Overview:
- Parametrised successor of the chip-level configuration register file on the fx bus.
- Generalised to NCH channels, each with:
  - a multi-byte threshold that updates atomically through a shadow register,
  - a channel enable,
  - a sticky event status bit,
  - a saturating event counter read with a snapshot.
- Adds maskable interrupt generation.
- Sits in chip_top between the fx bus decoder and the per-channel datapaths.

Parameters:
NCH, 4, number of channels, legal 1..8
TH_BYTES, 2, threshold width in bytes, legal 1..4; threshold width TW = 8*TH_BYTES
TH_RST, 32'h0000C000, threshold reset value, low TW bits used
CNT_W, 16, event counter width, fixed 16

Ports:
clk_sys  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
dev_id  input  6  device id compared against fx address bits [21:16]
fx_wr  input  1  write strobe, single cycle
fx_waddr  input  22  write address
fx_data  input  8  write data
fx_rd  input  1  read strobe, single cycle
fx_raddr  input  22  read address
fx_q  output  8  read data, valid the cycle after fx_rd
cfg_path_sel  output  8  path select
cfg_ch_en  output  NCH  per-channel enable
cfg_ch_th  output  NCH*TW  committed thresholds, channel n at [n*TW +: TW]
evt_in  input  NCH  per-channel event pulse, one cycle per event
irq  output  1  registered interrupt, level

Behaviour:
- Selection:
  - wsel = (fx_waddr[21:16] == dev_id); rsel likewise on fx_raddr.
  - Accesses with sel low are ignored.
  - Offsets below are fx_*addr[15:0].
- Clock and reset: one clock (clk_sys); reset is asynchronous and active-low (rst_n).
- Address map:
  - 0x0000 R: {2'b0, dev_id}.
  - 0x0001 R: NCH.
  - 0x0020 RW: cfg_path_sel.
  - 0x0021 RW: cfg_ch_en in bits [NCH-1:0]; upper bits read 0.
  - 0x0024 RW: irq_mask[NCH-1:0].
  - 0x0025 R: status[NCH-1:0]. Writing 1 to a bit clears it (W1C); writing 0 has no effect.
  - 0x0100 + ch*0x10 + b, b < TH_BYTES: threshold byte b, little-endian. Reads return committed cfg_ch_th bytes.
  - 0x0108 + ch*0x10: counter low byte. A read also snapshots the counter's high byte into hold[ch]. A write of any value clears the counter and hold[ch].
  - 0x0109 + ch*0x10: R, returns hold[ch], not the live counter.
  - Unmapped offsets, or ch >= NCH: writes ignored, reads return 8'h00.
- Threshold update (atomic):
  - A write to byte b < TH_BYTES-1 stores into shadow[ch] byte b only.
  - A write to top byte TH_BYTES-1 commits {fx_data, shadow[ch] lower bytes} to cfg_ch_th in that same clock edge.
  - The shadow is not cleared by a commit.
  - TH_BYTES = 1: every write commits directly.
- Status:
  - status[n] sets on evt_in[n].
  - Set wins over a simultaneous W1C of the same bit.
- Counter:
  - Increments on evt_in[n] only when cfg_ch_en[n] = 1.
  - Saturates at 0xFFFF, no wrap.
  - Clear and increment in the same cycle: counter becomes 1.
- Interrupt: irq <= |(status & irq_mask), registered, so it lags a status change by one cycle.
- Read timing:
  - fx_q is registered: data for a read with fx_rd high in cycle N appears in cycle N+1 and is 8'h00 in every other cycle.
  - Read and write to the same offset in the same cycle: the read returns the pre-write value.
  - A counter-low read in the same cycle as an increment snapshots the pre-increment value.
- Reset values:
  - cfg_path_sel = 0, cfg_ch_en = 0, irq_mask = 0, status = 0.
  - Counters = 0, hold = 0.
  - Shadow and cfg_ch_th = TH_RST[TW-1:0] per channel.
  - fx_q = 0, irq = 0.
  - Reset asserted mid-sequence (e.g. between a shadow write and its commit) restores all of these values; the pending shadow data is lost.

Test Plan:
- Reset, then read 0x0000, 0x0001 and 0x0101 with dev_id=6'h05 -> fx_q = 8'h05, 8'h04, 8'hC0, each one cycle after its fx_rd; fx_q = 0 in the intervening cycles.
- Write 0x0110=8'h34 -> cfg_ch_th for ch1 is still 16'hC000. Then write 0x0111=8'h12 -> ch1 becomes 16'h1234 on that edge, no intermediate 16'hC034. Same writes with waddr[21:16] != dev_id -> no change.
- Set cfg_ch_en=4'b0101, pulse evt_in=4'b1111 70000 times -> ch0 and ch2 counters = 16'hFFFF, ch1 and ch3 = 0, status = 4'b1111. Read 0x0108 then 0x0109 -> 8'hFF, 8'hFF.
- Set irq_mask=4'b0010, pulse evt_in[1] -> irq high the cycle after status[1] sets. Write 0x0025=8'h02 in the same cycle as another evt_in[1] -> status[1] stays 1. Repeat the W1C without an event -> status[1]=0, irq low one cycle later.
- Counter ch0 at 0x00FF: read 0x0108 (returns 8'hFF), apply 1 event, then read 0x0109 -> 8'h00 (snapshot), not 8'h01. Write 0x0108 in the same cycle as an event -> counter = 1.
- Write 0x0120=8'hAA (shadow only, no commit), assert rst_n low mid-sequence, release, then write 0x0121=8'h55 -> ch2 threshold = 16'h5500.

Source files
------------

// File: rtl/chip_regs_bank.sv
// Chip configuration register bank on the fx bus: path select, per-channel enables, shadowed thresholds, event status/counters, irq.
// Latency: reads return on fx_q one cycle after fx_rd; writes take effect on the strobe edge; irq lags status by one cycle.
// Backpressure: none, the fx bus is strobe-only, so every access completes in its cycle.
//
// Ports: clk_sys/rst_n clock and async active-low reset; dev_id selects this bank via addr[21:16];
//        fx_wr/fx_waddr/fx_data write strobe; fx_rd/fx_raddr/fx_q read strobe and registered data;
//        cfg_path_sel, cfg_ch_en, cfg_ch_th configuration outputs; evt_in per-channel events; irq level interrupt.
`timescale 1ns/1ps
module chip_regs_bank #(
    parameter int          NCH      = 4,
    parameter int          TH_BYTES = 2,
    parameter logic [31:0] TH_RST   = 32'h0000C000,
    parameter int          CNT_W    = 16
) (
    input  logic                      clk_sys,
    input  logic                      rst_n,
    input  logic [5:0]                dev_id,
    input  logic                      fx_wr,
    input  logic [21:0]               fx_waddr,
    input  logic [7:0]                fx_data,
    input  logic                      fx_rd,
    input  logic [21:0]               fx_raddr,
    output logic [7:0]                fx_q,
    output logic [7:0]                cfg_path_sel,
    output logic [NCH-1:0]            cfg_ch_en,
    output logic [NCH*8*TH_BYTES-1:0] cfg_ch_th,
    input  logic [NCH-1:0]            evt_in,
    output logic                      irq
);
    localparam int            TW      = 8 * TH_BYTES;
    localparam logic [TW-1:0] TH_INIT = TH_RST[TW-1:0];

    logic [7:0]       path_sel_q, path_sel_d;
    logic [NCH-1:0]   ch_en_q, ch_en_d;
    logic [NCH-1:0]   irq_mask_q, irq_mask_d;
    logic [NCH-1:0]   status_q, status_d;
    logic [TW-1:0]    shadow_q [NCH];
    logic [TW-1:0]    shadow_d [NCH];
    logic [TW-1:0]    th_q [NCH];
    logic [TW-1:0]    th_d [NCH];
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [7:0]       hold_q [NCH];
    logic [7:0]       hold_d [NCH];
    logic [7:0]       rd_q, rd_d;
    logic             irq_q, irq_d;

    // Address decode
    logic        wr_en, rd_en;
    logic [15:0] woff, roff;
    logic [3:0]  wb, rb;
    int          wch, rch, wbi, rbi;
    logic        w_chan, r_chan;   // offset lies in an implemented channel block
    logic [NCH-1:0] w1c, cnt_clr, inc;
    logic [7:0]  rdata;

    assign wr_en  = fx_wr && (fx_waddr[21:16] == dev_id);
    assign rd_en  = fx_rd && (fx_raddr[21:16] == dev_id);
    assign woff   = fx_waddr[15:0];
    assign roff   = fx_raddr[15:0];
    assign wb     = woff[3:0];
    assign rb     = roff[3:0];
    assign wbi    = int'(wb);
    assign rbi    = int'(rb);
    assign wch    = int'(woff[7:4]);
    assign rch    = int'(roff[7:4]);
    assign w_chan = (woff[15:8] == 8'h01) && (wch < NCH);
    assign r_chan = (roff[15:8] == 8'h01) && (rch < NCH);
    assign inc    = evt_in & ch_en_q;

    always_comb begin
        path_sel_d = path_sel_q;
        ch_en_d    = ch_en_q;
        irq_mask_d = irq_mask_q;
        shadow_d   = shadow_q;
        th_d       = th_q;
        w1c        = '0;
        cnt_clr    = '0;
        if (wr_en) begin
            case (woff)
                16'h0020: path_sel_d = fx_data;
                16'h0021: ch_en_d    = fx_data[NCH-1:0];
                16'h0024: irq_mask_d = fx_data[NCH-1:0];
                16'h0025: w1c        = fx_data[NCH-1:0];
                default: begin
                    if (w_chan) begin
                        if (wbi == TH_BYTES - 1) begin
                            // Top byte commits shadowed lower bytes together with the new byte.
                            th_d[wch]                 = shadow_q[wch];
                            th_d[wch][8*wbi +: 8]     = fx_data;
                        end else if (wbi < TH_BYTES - 1) begin
                            shadow_d[wch][8*wbi +: 8] = fx_data;
                        end else if (wb == 4'h8) begin
                            cnt_clr[wch] = 1'b1;
                        end
                    end
                end
            endcase
        end

        // A new event wins over a simultaneous write-1-to-clear.
        status_d = (status_q & ~w1c) | evt_in;

        for (int n = 0; n < NCH; n++) begin
            hold_d[n] = hold_q[n];
            if (rd_en && r_chan && (rch == n) && (rb == 4'h8))
                hold_d[n] = cnt_q[n][CNT_W-1:8];
            if (cnt_clr[n]) begin
                cnt_d[n]  = {{(CNT_W-1){1'b0}}, inc[n]};
                hold_d[n] = '0;
            end else if (inc[n] && (cnt_q[n] != '1)) begin
                cnt_d[n]  = cnt_q[n] + CNT_W'(1);
            end else begin
                cnt_d[n]  = cnt_q[n];
            end
        end
    end

    // Read mux works on pre-edge state, so same-cycle writes/increments are not visible.
    always_comb begin
        rdata = 8'h00;
        case (roff)
            16'h0000: rdata = {2'b00, dev_id};
            16'h0001: rdata = 8'(NCH);
            16'h0020: rdata = path_sel_q;
            16'h0021: rdata = 8'(ch_en_q);
            16'h0024: rdata = 8'(irq_mask_q);
            16'h0025: rdata = 8'(status_q);
            default: begin
                if (r_chan) begin
                    if (rbi < TH_BYTES)   rdata = th_q[rch][8*rbi +: 8];
                    else if (rb == 4'h8)  rdata = cnt_q[rch][7:0];
                    else if (rb == 4'h9)  rdata = hold_q[rch];
                end
            end
        endcase
    end

    assign rd_d  = rd_en ? rdata : 8'h00;
    assign irq_d = |(status_q & irq_mask_q);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            path_sel_q <= '0;
            ch_en_q    <= '0;
            irq_mask_q <= '0;
            status_q   <= '0;
            rd_q       <= '0;
            irq_q      <= 1'b0;
            for (int n = 0; n < NCH; n++) begin
                shadow_q[n] <= TH_INIT;
                th_q[n]     <= TH_INIT;
                cnt_q[n]    <= '0;
                hold_q[n]   <= '0;
            end
        end else begin
            path_sel_q <= path_sel_d;
            ch_en_q    <= ch_en_d;
            irq_mask_q <= irq_mask_d;
            status_q   <= status_d;
            rd_q       <= rd_d;
            irq_q      <= irq_d;
            for (int n = 0; n < NCH; n++) begin
                shadow_q[n] <= shadow_d[n];
                th_q[n]     <= th_d[n];
                cnt_q[n]    <= cnt_d[n];
                hold_q[n]   <= hold_d[n];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_th
        assign cfg_ch_th[g*TW +: TW] = th_q[g];
    end

    assign fx_q         = rd_q;
    assign irq          = irq_q;
    assign cfg_path_sel = path_sel_q;
    assign cfg_ch_en    = ch_en_q;

endmodule

// File: tb/tb_chip_regs_bank.sv
// Testbench for chip_regs_bank: vector table, directed corner sequences, then random traffic against a behavioural model.
// Latency: each step drives one bus cycle at the falling edge and compares outputs 1 ns after the rising edge.
// Backpressure: none on this bus.
`timescale 1ns/1ps
module tb_chip_regs_bank;
    localparam int         NCH      = 4;
    localparam int         TH_BYTES = 2;
    localparam int         TW       = 8 * TH_BYTES;
    localparam logic [5:0] DEV      = 6'h05;

    logic              clk_sys = 1'b0;
    logic              rst_n;
    logic [5:0]        dev_id;
    logic              fx_wr;
    logic [21:0]       fx_waddr;
    logic [7:0]        fx_data;
    logic              fx_rd;
    logic [21:0]       fx_raddr;
    logic [7:0]        fx_q;
    logic [7:0]        cfg_path_sel;
    logic [NCH-1:0]    cfg_ch_en;
    logic [NCH*TW-1:0] cfg_ch_th;
    logic [NCH-1:0]    evt_in;
    logic              irq;

    chip_regs_bank #(.NCH(NCH), .TH_BYTES(TH_BYTES), .TH_RST(32'h0000C000), .CNT_W(16)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .dev_id(dev_id),
        .fx_wr(fx_wr), .fx_waddr(fx_waddr), .fx_data(fx_data),
        .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q),
        .cfg_path_sel(cfg_path_sel), .cfg_ch_en(cfg_ch_en), .cfg_ch_th(cfg_ch_th),
        .evt_in(evt_in), .irq(irq)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b1;

    // Behavioural model state (plain integers)
    int m_path, m_en, m_mask, m_stat, m_q, m_irq;
    int m_sh[NCH], m_th[NCH], m_cnt[NCH], m_hold[NCH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_path = 0; m_en = 0; m_mask = 0; m_stat = 0; m_q = 0; m_irq = 0;
        for (int n = 0; n < NCH; n++) begin
            m_sh[n] = 'hC000; m_th[n] = 'hC000; m_cnt[n] = 0; m_hold[n] = 0;
        end
    endtask

    function automatic int mread(input int off);
        int ch, b;
        case (off)
            'h0000: return int'(DEV);
            'h0001: return NCH;
            'h0020: return m_path;
            'h0021: return m_en;
            'h0024: return m_mask;
            'h0025: return m_stat;
            default: ;
        endcase
        if (off >= 'h100 && off < 'h200) begin
            ch = (off - 'h100) / 16;
            b  = off % 16;
            if (ch < NCH) begin
                if (b < TH_BYTES) return (m_th[ch] >> (8 * b)) & 'hFF;
                if (b == 8)       return m_cnt[ch] & 'hFF;
                if (b == 9)       return m_hold[ch];
            end
        end
        return 0;
    endfunction

    // One clock edge of the register bank, applied to the model from its pre-edge state.
    task automatic model_edge(input logic wr, input logic [21:0] wa, input logic [7:0] wd,
                              input logic rd, input logic [21:0] ra, input logic [3:0] ev);
        int nq, nirq, woff, roff, ch, b, old_en, clr, w1c, inc, mask_b;
        woff   = int'(wa[15:0]);
        roff   = int'(ra[15:0]);
        old_en = m_en;
        clr    = 0;
        w1c    = 0;
        nq     = (rd && ra[21:16] == DEV) ? mread(roff) : 0;
        nirq   = ((m_stat & m_mask) != 0) ? 1 : 0;
        if (rd && ra[21:16] == DEV && roff >= 'h100 && roff < 'h200 &&
            (roff - 'h100) / 16 < NCH && roff % 16 == 8)
            m_hold[(roff - 'h100) / 16] = m_cnt[(roff - 'h100) / 16] >> 8;
        if (wr && wa[21:16] == DEV) begin
            case (woff)
                'h0020: m_path = int'(wd);
                'h0021: m_en   = int'(wd) & ((1 << NCH) - 1);
                'h0024: m_mask = int'(wd) & ((1 << NCH) - 1);
                'h0025: w1c    = int'(wd) & ((1 << NCH) - 1);
                default: begin
                    if (woff >= 'h100 && woff < 'h200 && (woff - 'h100) / 16 < NCH) begin
                        ch     = (woff - 'h100) / 16;
                        b      = woff % 16;
                        mask_b = 'hFF << (8 * b);
                        if (b < TH_BYTES - 1)
                            m_sh[ch] = (m_sh[ch] & ~mask_b) | (int'(wd) << (8 * b));
                        else if (b == TH_BYTES - 1)
                            m_th[ch] = (m_sh[ch] & ~mask_b) | (int'(wd) << (8 * b));
                        else if (b == 8)
                            clr = clr | (1 << ch);
                    end
                end
            endcase
        end
        m_stat = (m_stat & ~w1c) | int'(ev);
        for (int n = 0; n < NCH; n++) begin
            inc = (ev[n] && old_en[n]) ? 1 : 0;
            if (clr[n]) begin
                m_cnt[n]  = inc;
                m_hold[n] = 0;
            end else begin
                m_cnt[n] = (m_cnt[n] + inc > 65535) ? 65535 : m_cnt[n] + inc;
            end
        end
        m_q   = nq;
        m_irq = nirq;
    endtask

    task automatic check_all(input string tag);
        logic [63:0] eth;
        eth = '0;
        for (int n = 0; n < NCH; n++) eth[n*TW +: TW] = TW'(m_th[n]);
        chk({tag, ".fx_q"},     64'(fx_q),         64'(m_q));
        chk({tag, ".irq"},      64'(irq),          64'(m_irq));
        chk({tag, ".path_sel"}, 64'(cfg_path_sel), 64'(m_path));
        chk({tag, ".ch_en"},    64'(cfg_ch_en),    64'(m_en));
        chk({tag, ".ch_th"},    64'(cfg_ch_th),    eth);
    endtask

    task automatic step(input logic wr, input logic [21:0] wa, input logic [7:0] wd,
                        input logic rd, input logic [21:0] ra, input logic [3:0] ev);
        @(negedge clk_sys);
        fx_wr = wr; fx_waddr = wa; fx_data = wd; fx_rd = rd; fx_raddr = ra; evt_in = ev;
        @(posedge clk_sys);
        model_edge(wr, wa, wd, rd, ra, ev);
        #1;
        if (check_en) check_all("cyc");
    endtask

    task automatic wr_reg(input logic [15:0] off, input logic [7:0] d);
        step(1'b1, {DEV, off}, d, 1'b0, 22'h0, 4'h0);
    endtask

    task automatic rd_chk(input string name, input logic [15:0] off, input logic [7:0] exp);
        step(1'b0, 22'h0, 8'h00, 1'b1, {DEV, off}, 4'h0);
        chk(name, 64'(fx_q), 64'(exp));
    endtask

    typedef struct {
        logic        wr;
        logic [21:0] wa;
        logic [7:0]  wd;
        logic        rd;
        logic [21:0] ra;
        logic [7:0]  exp_q;
    } vec_t;

    vec_t vt[19];
    int   bsel[5] = '{0, 1, 2, 8, 9};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        r_wr, r_rd;
        logic [21:0] r_wa, r_ra;
        logic [7:0]  r_wd;
        logic [3:0]  r_ev;
        logic [15:0] off;

        vt[0]  = '{1'b0, 22'h0,      8'h00, 1'b1, 22'h050000, 8'h05};
        vt[1]  = '{1'b0, 22'h0,      8'h00, 1'b0, 22'h0,      8'h00};
        vt[2]  = '{1'b0, 22'h0,      8'h00, 1'b1, 22'h050001, 8'h04};
        vt[3]  = '{1'b0, 22'h0,      8'h00, 1'b0, 22'h0,      8'h00};
        vt[4]  = '{1'b0, 22'h0,      8'h00, 1'b1, 22'h050101, 8'hC0};
        vt[5]  = '{1'b0, 22'h0,      8'h00, 1'b1, 22'h050100, 8'h00};
        vt[6]  = '{1'b1, 22'h050020, 8'hA5, 1'b0, 22'h0,      8'h00};
        vt[7]  = '{1'b0, 22'h0,      8'h00, 1'b1, 22'h050020, 8'hA5};
        vt[8]  = '{1'b1, 22'h050024, 8'hF3, 1'b1, 22'h050024, 8'h00};
        vt[9]  = '{1'b0, 22'h0,      8'h00, 1'b1, 22'h050024, 8'h03};
        vt[10] = '{1'b1, 22'h070020, 8'h11, 1'b1, 22'h050020, 8'hA5};
        vt[11] = '{1'b0, 22'h0,      8'h00, 1'b1, 22'h050020, 8'hA5};
        vt[12] = '{1'b0, 22'h0,      8'h00, 1'b1, 22'h060000, 8'h00};
        vt[13] = '{1'b0, 22'h0,      8'h00, 1'b1, 22'h050140, 8'h00};
        vt[14] = '{1'b0, 22'h0,      8'h00, 1'b1, 22'h050030, 8'h00};
        vt[15] = '{1'b1, 22'h050024, 8'h00, 1'b1, 22'h050021, 8'h00};
        vt[16] = '{1'b1, 22'h050021, 8'hFF, 1'b1, 22'h050001, 8'h04};
        vt[17] = '{1'b0, 22'h0,      8'h00, 1'b1, 22'h050021, 8'h0F};
        vt[18] = '{1'b1, 22'h050021, 8'h00, 1'b0, 22'h0,      8'h00};

        rst_n = 1'b0; dev_id = DEV;
        fx_wr = 1'b0; fx_waddr = '0; fx_data = '0; fx_rd = 1'b0; fx_raddr = '0; evt_in = '0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk_sys);
        rst_n = 1'b1;

        // Register map vectors
        for (int i = 0; i < 19; i++) begin
            step(vt[i].wr, vt[i].wa, vt[i].wd, vt[i].rd, vt[i].ra, 4'h0);
            chk($sformatf("vec%0d.fx_q", i), 64'(fx_q), 64'(vt[i].exp_q));
        end

        // Atomic threshold update
        wr_reg(16'h0110, 8'h34);
        chk("th_shadow_only", 64'(cfg_ch_th[31:16]), 64'h C000);
        wr_reg(16'h0111, 8'h12);
        chk("th_commit", 64'(cfg_ch_th[31:16]), 64'h1234);
        step(1'b1, 22'h0A0110, 8'h99, 1'b0, 22'h0, 4'h0);
        step(1'b1, 22'h0A0111, 8'h88, 1'b0, 22'h0, 4'h0);
        chk("th_wrong_dev", 64'(cfg_ch_th[31:16]), 64'h1234);

        // Counter saturation
        wr_reg(16'h0021, 8'h05);
        check_en = 1'b0;
        for (int i = 0; i < 70000; i++) step(1'b0, 22'h0, 8'h00, 1'b0, 22'h0, 4'hF);
        check_en = 1'b1;
        rd_chk("sat_ch0_lo", 16'h0108, 8'hFF);
        rd_chk("sat_ch0_hi", 16'h0109, 8'hFF);
        rd_chk("sat_ch2_lo", 16'h0128, 8'hFF);
        rd_chk("sat_ch2_hi", 16'h0129, 8'hFF);
        rd_chk("dis_ch1_lo", 16'h0118, 8'h00);
        rd_chk("dis_ch3_lo", 16'h0138, 8'h00);
        rd_chk("sat_status", 16'h0025, 8'h0F);

        // Interrupt and W1C priority
        wr_reg(16'h0025, 8'h0F);
        wr_reg(16'h0024, 8'h02);
        step(1'b0, 22'h0, 8'h00, 1'b0, 22'h0, 4'h2);
        chk("irq_lag", 64'(irq), 64'h0);
        step(1'b0, 22'h0, 8'h00, 1'b0, 22'h0, 4'h0);
        chk("irq_set", 64'(irq), 64'h1);
        step(1'b1, {DEV, 16'h0025}, 8'h02, 1'b0, 22'h0, 4'h2);
        rd_chk("w1c_vs_set", 16'h0025, 8'h02);
        wr_reg(16'h0025, 8'h02);
        chk("irq_hold_after_w1c", 64'(irq), 64'h1);
        rd_chk("w1c_clear", 16'h0025, 8'h00);
        chk("irq_clear", 64'(irq), 64'h0);

        // Snapshot and clear corner cases on channel 0
        wr_reg(16'h0108, 8'h00);
        for (int i = 0; i < 255; i++) step(1'b0, 22'h0, 8'h00, 1'b0, 22'h0, 4'h1);
        rd_chk("cnt_ff_lo", 16'h0108, 8'hFF);
        step(1'b0, 22'h0, 8'h00, 1'b0, 22'h0, 4'h1);
        rd_chk("cnt_snapshot_hi", 16'h0109, 8'h00);
        rd_chk("cnt_100_lo", 16'h0108, 8'h00);
        step(1'b1, {DEV, 16'h0108}, 8'h5A, 1'b0, 22'h0, 4'h1);
        rd_chk("clr_and_inc", 16'h0108, 8'h01);
        step(1'b0, 22'h0, 8'h00, 1'b1, {DEV, 16'h0108}, 4'h1);
        chk("rd_pre_inc", 64'(fx_q), 64'h01);
        rd_chk("post_inc", 16'h0108, 8'h02);

        // Reset between a shadow write and its commit
        wr_reg(16'h0120, 8'hAA);
        @(negedge clk_sys);
        fx_wr = 1'b0; fx_rd = 1'b0; evt_in = '0;
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("mid_reset");
        #1;
        rst_n = 1'b1;
        wr_reg(16'h0121, 8'h55);
        chk("th_after_reset", 64'(cfg_ch_th[47:32]), 64'h5500);
        rd_chk("cnt_after_reset", 16'h0108, 8'h00);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r_wr = ($urandom_range(0, 2) == 0);
            r_rd = ($urandom_range(0, 1) == 0);
            r_wd = 8'($urandom);
            r_ev = 4'($urandom) & 4'($urandom);
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 9))
                    0: off = 16'h0000;
                    1: off = 16'h0001;
                    2: off = 16'h0020;
                    3: off = 16'h0021;
                    4: off = 16'h0024;
                    5: off = 16'h0025;
                    6: off = 16'h0030;
                    default: off = 16'(16'h0100 + 16 * $urandom_range(0, NCH) + bsel[$urandom_range(0, 4)]);
                endcase
                if (k == 0) r_wa = {($urandom_range(0, 9) == 0) ? 6'h2A : DEV, off};
                else        r_ra = {($urandom_range(0, 9) == 0) ? 6'h2A : DEV, off};
            end
            // Counter-low clear and snapshot in one cycle on the same channel is left out.
            if (r_wr && r_rd && r_wa[15:0] == r_ra[15:0] && r_ra[15:8] == 8'h01 && r_ra[3:0] == 4'h8)
                r_rd = 1'b0;
            step(r_wr, r_wa, r_wd, r_rd, r_ra, r_ev);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
